// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC follower: q-format widths, gain constant,
// quadrant codes, FSM states and the q1.15 saturation helper.
package cordic_pkg;

  localparam int Q115_W = 16;
  localparam int Q315_W = 18;

  // 0.6073 in unsigned q0.16
  localparam logic [17:0] K_SCALE = 18'h09B78;

  localparam logic [1:0] QUAD_1_4 = 2'b00;
  localparam logic [1:0] QUAD_2   = 2'b10;
  localparam logic [1:0] QUAD_3   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_SCALE  = 2'd2
  } state_t;

  // Clamp a q3.15 value (held in a wide signed container) into q1.15.
  function automatic logic [15:0] sat_q115(input logic signed [34:0] v);
    if (v > 35'sd32767)
      return 16'h7FFF;
    else if (v < -35'sd32768)
      return 16'h8000;
    else
      return v[15:0];
  endfunction

endpackage

// File: rtl/cordic_scale_sat.sv
// Gain compensation for one CORDIC lane: q3.15 x K (q0.16) -> q3.15, then
// saturated to q1.15. Purely combinational; the caller registers the result.
module cordic_scale_sat
  import cordic_pkg::*;
#(
  parameter logic [17:0] K = cordic_pkg::K_SCALE
) (
  input  logic [17:0] i_val,
  output logic [15:0] o_sat
);

  logic signed [34:0] w_a;
  logic signed [34:0] w_b;
  logic signed [34:0] w_prod;
  logic signed [34:0] w_shifted;

  // Signed datapath operand against a zero-extended 17-bit gain gives a q3.31
  // product that always fits in 35 bits.
  assign w_a       = {{17{i_val[17]}}, i_val};
  assign w_b       = {18'd0, K[16:0]};
  assign w_prod    = w_a * w_b;
  assign w_shifted = w_prod >>> 16;
  assign o_sat     = sat_q115(w_shifted);

endmodule

// File: rtl/rv_cordic_follower.sv
// Rotation-mode CORDIC that replays the micro-rotation directions found by a
// vectoring CORDIC onto a second vector, then gain-compensates and saturates.
module rv_cordic_follower #(
  parameter int          WIDTH    = cordic_pkg::Q315_W,
  parameter int          MAX_ITER = 16,
  parameter logic [17:0] K_SCALE  = cordic_pkg::K_SCALE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic [31:0] di_micro_rot,
  input  logic [1:0]  quadrant,
  input  logic [7:0]  N,
  output logic        busy,
  output logic        done,
  output logic [15:0] x_out,
  output logic [15:0] y_out
);

  import cordic_pkg::*;

  localparam int CNT_W = $clog2(MAX_ITER + 1);

  state_t                    r_state;
  state_t                    w_next;
  logic signed [WIDTH-1:0]   r_x;
  logic signed [WIDTH-1:0]   r_y;
  logic [31:0]               r_di;
  logic [CNT_W-1:0]          r_neff;
  logic [CNT_W-1:0]          r_itn;
  logic                      r_busy;
  logic                      r_done;
  logic [15:0]               r_xout;
  logic [15:0]               r_yout;

  logic [CNT_W-1:0]          w_neff;
  logic                      w_last;
  logic signed [WIDTH-1:0]   w_xq;
  logic signed [WIDTH-1:0]   w_yq;
  logic signed [WIDTH-1:0]   w_xsh;
  logic signed [WIDTH-1:0]   w_ysh;
  logic [15:0]               w_xsat;
  logic [15:0]               w_ysat;

  assign w_neff = (N > 8'(MAX_ITER)) ? CNT_W'(MAX_ITER) : CNT_W'(N);
  assign w_last = (r_itn == r_neff - CNT_W'(1));
  assign w_xsh  = r_x >>> r_itn;
  assign w_ysh  = r_y >>> r_itn;

  // Sign-extend the q1.15 operands and apply the quadrant pre-rotation.
  always_comb begin
    w_xq = WIDTH'($signed(x_in));
    w_yq = WIDTH'($signed(y_in));
    case (quadrant)
      QUAD_2:  w_xq = -WIDTH'($signed(x_in));
      QUAD_3: begin
        w_xq = -WIDTH'($signed(x_in));
        w_yq = -WIDTH'($signed(y_in));
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = (w_neff != '0) ? ST_ROTATE : ST_SCALE;
      ST_ROTATE: if (w_last) w_next = ST_SCALE;
      ST_SCALE:  w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  cordic_scale_sat #(.K(K_SCALE)) u_scale_x (.i_val(r_x), .o_sat(w_xsat));
  cordic_scale_sat #(.K(K_SCALE)) u_scale_y (.i_val(r_y), .o_sat(w_ysat));

  // Operand capture, one micro-rotation per cycle, and output registration.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_di   <= '0;
      r_neff <= '0;
      r_itn  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_xout <= '0;
      r_yout <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_di   <= di_micro_rot;
            r_neff <= w_neff;
            r_x    <= w_xq;
            r_y    <= w_yq;
            r_itn  <= '0;
            r_busy <= 1'b1;
          end
        end
        ST_ROTATE: begin
          // di bit set means d = -1 (clockwise); wrap-around is intended.
          if (r_di[r_itn]) begin
            r_x <= r_x + w_ysh;
            r_y <= r_y - w_xsh;
          end else begin
            r_x <= r_x - w_ysh;
            r_y <= r_y + w_xsh;
          end
          r_itn <= r_itn + CNT_W'(1);
        end
        ST_SCALE: begin
          r_xout <= w_xsat;
          r_yout <= w_ysat;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign x_out = r_xout;
  assign y_out = r_yout;

endmodule

// File: tb/tb_rv_cordic_follower.sv
// Randomized bench for rv_cordic_follower against an integer-arithmetic model.
module tb_rv_cordic_follower;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic [31:0] di;
  logic [1:0]  quad;
  logic [7:0]  N;
  logic        busy;
  logic        done;
  logic [15:0] x_out;
  logic [15:0] y_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rv_cordic_follower dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in),
    .di_micro_rot(di), .quadrant(quad), .N(N),
    .busy(busy), .done(done), .x_out(x_out), .y_out(y_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int wrap18(input longint v);
    longint m;
    m = v & 64'h3FFFF;
    if (m >= 64'h20000) m = m - 64'h40000;
    return int'(m);
  endfunction

  function automatic logic [15:0] sat16(input longint v);
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  // Golden model: CORDIC rotation on plain integers, then x0.6073 (q0.16).
  task automatic model(input logic [15:0] xi, input logic [15:0] yi,
                       input logic [31:0] d, input logic [1:0] q,
                       input logic [7:0] n, output logic [15:0] xo,
                       output logic [15:0] yo, output int lat);
    int x, y, xn, yn, ne;
    x = int'($signed(xi));
    y = int'($signed(yi));
    if (q == 2'b10) x = -x;
    if (q == 2'b11) begin x = -x; y = -y; end
    ne = (n > 16) ? 16 : int'(n);
    for (int i = 0; i < ne; i++) begin
      if (d[i]) begin
        xn = x + (y >>> i);
        yn = y - (x >>> i);
      end else begin
        xn = x - (y >>> i);
        yn = y + (x >>> i);
      end
      x = wrap18(longint'(xn));
      y = wrap18(longint'(yn));
    end
    xo  = sat16((longint'(x) * 39800) >>> 16);
    yo  = sat16((longint'(y) * 39800) >>> 16);
    lat = ne + 1;
  endtask

  // Issue one operation, wait (bounded) for done, compare timing and results.
  task automatic do_op(input string tag, input logic [15:0] xi, input logic [15:0] yi,
                       input logic [31:0] d, input logic [1:0] q, input logic [7:0] n);
    logic [15:0] ex, ey;
    int lat, e;
    bit seen;
    model(xi, yi, d, q, n, ex, ey, lat);
    x_in = xi; y_in = yi; di = d; quad = q; N = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy_start"}, 32'(busy), 32'd1);
    e = 0;
    seen = 1'b0;
    while (e < 60 && !seen) begin
      @(posedge clk); #1;
      e++;
      if (done) seen = 1'b1;
    end
    check({tag, " latency"}, 32'(e), 32'(lat));
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    check({tag, " x_out"}, 32'(x_out), 32'(ex));
    check({tag, " y_out"}, 32'(y_out), 32'(ey));
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " x_hold"}, 32'(x_out), 32'(ex));
  endtask

  logic [15:0] ex, ey;
  int          lat, e;
  bit          seen;

  initial begin
    rst = 1'b0; start = 1'b0; x_in = '0; y_in = '0; di = '0; quad = '0; N = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst x_out", 32'(x_out), 32'd0);
    check("rst y_out", 32'(y_out), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases with hand-derived results.
    do_op("dir1", 16'h4000, 16'h0000, 32'h0, 2'b00, 8'd1);
    check("dir1 x_const", 32'(x_out), 32'h26DE);
    check("dir1 y_const", 32'(y_out), 32'h26DE);
    do_op("dir2", 16'h4000, 16'h2000, 32'h0, 2'b11, 8'd0);
    check("dir2 x_const", 32'(x_out), 32'hD922);
    check("dir2 y_const", 32'(y_out), 32'hEC91);
    do_op("dir3", 16'h7FFF, 16'h7FFF, 32'h0, 2'b00, 8'd1);
    check("dir3 x_const", 32'(x_out), 32'h0000);
    check("dir3 y_const", 32'(y_out), 32'h7FFF);
    do_op("quad01", 16'h3000, 16'hD000, 32'h5, 2'b01, 8'd3);
    do_op("quad10", 16'h3000, 16'hD000, 32'h5, 2'b10, 8'd3);

    // Randomized runs: full length, clamped length, and mixed lengths.
    for (int i = 0; i < 12; i++)
      do_op("rnd16", 16'($urandom), 16'($urandom), $urandom, 2'($urandom), 8'd16);
    for (int i = 0; i < 4; i++)
      do_op("rnd40", 16'($urandom), 16'($urandom), $urandom, 2'($urandom), 8'd40);
    for (int i = 0; i < 8; i++)
      do_op("rndN", 16'($urandom), 16'($urandom), $urandom, 2'($urandom),
            8'($urandom_range(0, 20)));

    // start re-pulsed while busy must not disturb the running operation.
    model(16'h2345, 16'hE123, 32'hA5A5_3C3C, 2'b00, 8'd16, ex, ey, lat);
    x_in = 16'h2345; y_in = 16'hE123; di = 32'hA5A5_3C3C; quad = 2'b00; N = 8'd16;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    x_in = 16'h7000; y_in = 16'h1000; di = 32'hFFFF_FFFF; quad = 2'b11; N = 8'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = 3;
    seen = 1'b0;
    while (e < 60 && !seen) begin
      @(posedge clk); #1;
      e++;
      if (done) seen = 1'b1;
    end
    check("repulse latency", 32'(e), 32'(lat));
    check("repulse x_out", 32'(x_out), 32'(ex));
    check("repulse y_out", 32'(y_out), 32'(ey));

    // Reset in the middle of a run aborts it with no done pulse.
    @(posedge clk); #1;
    x_in = 16'h1111; y_in = 16'h2222; di = $urandom; quad = 2'b00; N = 8'd16;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst x_out", 32'(x_out), 32'd0);
    check("midrst y_out", 32'(y_out), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("midrst quiet", 32'(seen), 32'd0);
    do_op("postrst", 16'($urandom), 16'($urandom), $urandom, 2'($urandom), 8'd16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
